// File: rtl/load_store_ctrl.sv
// RV32I load/store bus controller: IDLE -> BUSY -> DONE handshake with lane steering and timeout abort.
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
module load_store_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic        busReady,
    input  logic [31:0] busRdata,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busSel,
    output logic        busRen,
    output logic        busWen,
    output logic        stall,
    output logic [31:0] memload,
    output logic        loadValid,
    output logic        busErr,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  count;
    logic [1:0]  size;
    logic [1:0]  a_lo;
    logic        is_read;
    logic        timed_out;
    logic        req;
    logic        misal_req;
    logic        at_limit;
    logic [3:0]  sel_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_calc;
    logic        unused_sign;

    // sign/zero extension happens in writeback, so the unsigned bit is not needed here
    assign unused_sign = funct3[2];

    assign req      = memRead | memWrite;
    assign at_limit = (count == 8'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    logic trap;
    assign misal_req  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        (funct3[1] && (addr[1:0] != 2'b00));
    assign misaligned = (state == DONE) && trap;
`else
    assign misal_req  = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        sel_calc   = 4'b1111;
        wdata_calc = storeData;
        case (funct3[1:0])
            2'b00: begin
                sel_calc   = 4'b0001 << addr[1:0];
                wdata_calc = {4{storeData[7:0]}};
            end
            2'b01: begin
                sel_calc   = 4'b0011 << {addr[1], 1'b0};
                wdata_calc = {2{storeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_calc = busRdata;
        case (size)
            2'b00:   load_calc = busRdata >> {a_lo, 3'b000};
            2'b01:   load_calc = busRdata >> {a_lo[1], 4'b0000};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = misal_req ? DONE : BUSY;
            BUSY: if (busReady || at_limit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall     = ((state == IDLE) && req) || (state == BUSY);
    assign loadValid = (state == DONE) && is_read && !timed_out
`ifdef LSU_MISALIGN_TRAP_EN
                       && !trap
`endif
                       ;
    assign busErr    = (state == DONE) && timed_out;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state     <= IDLE;
            count     <= '0;
            size      <= '0;
            a_lo      <= '0;
            is_read   <= 1'b0;
            timed_out <= 1'b0;
            busAddr   <= '0;
            busWdata  <= '0;
            busSel    <= '0;
            busRen    <= 1'b0;
            busWen    <= 1'b0;
            memload   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            trap      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req) begin
                    count     <= '0;
                    size      <= funct3[1:0];
                    a_lo      <= addr[1:0];
                    is_read   <= memRead;
                    timed_out <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    trap      <= misal_req;
`endif
                    if (!misal_req) begin
                        busAddr  <= {addr[31:2], 2'b00};
                        busSel   <= sel_calc;
                        busWdata <= wdata_calc;
                        busRen   <= memRead;
                        busWen   <= memWrite & ~memRead;
                    end
                end
                BUSY: begin
                    if (busReady) begin
                        busRen <= 1'b0;
                        busWen <= 1'b0;
                        if (is_read) memload <= load_calc;
                    end else if (at_limit) begin
                        busRen    <= 1'b0;
                        busWen    <= 1'b0;
                        timed_out <= 1'b1;
                        memload   <= '0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
